gray_ptr_decoder: RTL and testbench



---
 rtl/gray_pkg.sv | 34 +++
 rtl/gray_ptr_decoder_if.sv | 26 ++
 rtl/gray_sync.sv | 31 +++
 rtl/gray_ptr_decoder.sv | 97 +++++++++
 tb/tb_gray_ptr_decoder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: bin2gray, gray2bin, popcount.
// Functions work on MAX_W-bit words; callers zero-extend narrower values
// and truncate results. Zero extension is harmless for both conversions.
package gray_pkg;

  localparam int ERR_CNT_W = 8;
  localparam int MAX_W     = 32;

  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Pure XOR cascade from the MSB down, no carry chain.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input word_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_ptr_decoder_if.sv
// Bundle between the Gray pointer source side and the decoder.
// master: consumer logic driving gray_in / clr_err and reading results.
// slave : the decoder itself.
interface gray_ptr_decoder_if
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]     gray_in;
  logic                 clr_err;
  logic [WIDTH-1:0]     bin_out;
  logic                 bin_valid;
  logic                 up;
  logic                 step_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output gray_in, clr_err,
    input  bin_out, bin_valid, up, step_err, err_cnt
  );

  modport slave (
    input  gray_in, clr_err,
    output bin_out, bin_valid, up, step_err, err_cnt
  );
endinterface

// File: rtl/gray_sync.sv
// Per-bit multi-flop synchronizer for an asynchronous Gray bus.
// STAGES flops deep (legal 2..4), async active-low reset to zero.
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the async input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_decoder.sv
// Receive-side Gray pointer decoder: synchronize, decode to binary,
// strobe on change, report direction and flag multi-bit steps.
// Optional macro GRAY_PTR_DECODER_ERR_CNT_EN builds a saturating
// illegal-step counter on err_cnt; otherwise err_cnt is tied to zero.
module gray_ptr_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_ptr_decoder_if.slave   bus
);

  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] g_prev;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] bin_inc;
  logic             valid_q;
  logic             up_q;
  logic             err_q;
  logic             changed;
  logic             illegal;

  gray_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.gray_in),
    .q     (g_s)
  );

  // Decode and step classification of the synchronized value.
  always_comb begin
    bin_next = WIDTH'(gray2bin(MAX_W'(g_s)));
    bin_inc  = bin_q + WIDTH'(1);
    changed  = (g_s != g_prev);
    illegal  = (popcount(MAX_W'(g_s ^ g_prev)) > 1);
  end

  // Compare/decode stage; a multi-bit step is still accepted, only flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_prev  <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      valid_q <= changed;
      if (changed) begin
        g_prev <= g_s;
        bin_q  <= bin_next;
        up_q   <= (bin_next == bin_inc);
      end
    end
  end

  // Sticky error flag; a new illegal step wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (illegal) begin
      err_q <= 1'b1;
    end else if (bus.clr_err) begin
      err_q <= 1'b0;
    end
  end

`ifdef GRAY_PTR_DECODER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt_q;

  // Saturating illegal-step counter; clear plus a new error leaves 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.clr_err) begin
      cnt_q <= illegal ? ERR_CNT_W'(1) : '0;
    end else if (illegal && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ERR_CNT_W'(1);
    end
  end

  assign bus.err_cnt = cnt_q;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.bin_out   = bin_q;
  assign bus.bin_valid = valid_q;
  assign bus.up        = up_q;
  assign bus.step_err  = err_q;

endmodule

// File: tb/tb_gray_ptr_decoder.sv
// Directed self-checking bench for gray_ptr_decoder (WIDTH=4, SYNC_STAGES=2).
module tb_gray_ptr_decoder;
  import gray_pkg::*;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   pass_cnt;

  // Hand-written 4-bit Gray sequence, index = binary value.
  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_ptr_decoder_if #(.WIDTH(4)) bus ();

  gray_ptr_decoder #(
    .WIDTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [3:0] g);
    bus.gray_in = g;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0;
    bus.gray_in = 4'b0000;
    bus.clr_err = 1'b0;
    #12;
    chk_cnt++; if (bus.bin_out !== 4'd0) $display("FAIL rst_bin got %0d exp 0", bus.bin_out); else pass_cnt++;
    chk_cnt++; if (bus.bin_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.bin_valid); else pass_cnt++;
    chk_cnt++; if (bus.up !== 1'b0) $display("FAIL rst_up got %b exp 0", bus.up); else pass_cnt++;
    chk_cnt++; if (bus.step_err !== 1'b0) $display("FAIL rst_err got %b exp 0", bus.step_err); else pass_cnt++;
    chk_cnt++; if (bus.err_cnt !== 8'd0) $display("FAIL rst_cnt got %0d exp 0", bus.err_cnt); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.bin_valid === 1'b1) seen++;
    end
    chk_cnt++; if (seen != 0) $display("FAIL idle_valid pulses got %0d exp 0", seen); else pass_cnt++;
    chk_cnt++; if (bus.bin_out !== 4'd0) $display("FAIL idle_bin got %0d exp 0", bus.bin_out); else pass_cnt++;
    chk_cnt++; if (bus.step_err !== 1'b0) $display("FAIL idle_err got %b exp 0", bus.step_err); else pass_cnt++;
  endtask

  task automatic test_sequence();
    for (int b = 1; b < 16; b++) begin
      bus.gray_in = gtab[b];
      tick(); tick();
      chk_cnt++; if (bus.bin_valid !== 1'b0) $display("FAIL seq_early_valid b=%0d got %b exp 0", b, bus.bin_valid); else pass_cnt++;
      tick();
      chk_cnt++; if (bus.bin_valid !== 1'b1) $display("FAIL seq_valid b=%0d got %b exp 1", b, bus.bin_valid); else pass_cnt++;
      chk_cnt++; if (bus.bin_out !== 4'(b)) $display("FAIL seq_bin got %0d exp %0d", bus.bin_out, b); else pass_cnt++;
      chk_cnt++; if (bus.up !== 1'b1) $display("FAIL seq_up b=%0d got %b exp 1", b, bus.up); else pass_cnt++;
      chk_cnt++; if (bus.step_err !== 1'b0) $display("FAIL seq_err b=%0d got %b exp 0", b, bus.step_err); else pass_cnt++;
      tick();
      chk_cnt++; if (bus.bin_valid !== 1'b0) $display("FAIL seq_pulse_end b=%0d got %b exp 0", b, bus.bin_valid); else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    // Gray 1000 -> 0000 is a legal wrap from 15 to 0.
    bus.gray_in = 4'b0000;
    repeat (3) tick();
    chk_cnt++; if (bus.bin_valid !== 1'b1) $display("FAIL wrap_valid got %b exp 1", bus.bin_valid); else pass_cnt++;
    chk_cnt++; if (bus.bin_out !== 4'd0) $display("FAIL wrap_bin got %0d exp 0", bus.bin_out); else pass_cnt++;
    chk_cnt++; if (bus.up !== 1'b1) $display("FAIL wrap_up got %b exp 1", bus.up); else pass_cnt++;
    chk_cnt++; if (bus.step_err !== 1'b0) $display("FAIL wrap_err got %b exp 0", bus.step_err); else pass_cnt++;
    tick();
    // 0000 -> 0101 (bin 6) flips two bits.
    bus.gray_in = 4'b0101;
    repeat (3) tick();
    chk_cnt++; if (bus.bin_out !== 4'd6) $display("FAIL jump_bin got %0d exp 6", bus.bin_out); else pass_cnt++;
    chk_cnt++; if (bus.up !== 1'b0) $display("FAIL jump_up got %b exp 0", bus.up); else pass_cnt++;
    chk_cnt++; if (bus.step_err !== 1'b1) $display("FAIL jump_err got %b exp 1", bus.step_err); else pass_cnt++;
    chk_cnt++; if (bus.bin_valid !== 1'b1) $display("FAIL jump_valid got %b exp 1", bus.bin_valid); else pass_cnt++;
    tick();
    // Down count 6 -> 5: legal, up=0.
    settle(4'b0111);
    chk_cnt++; if (bus.bin_out !== 4'd5) $display("FAIL down_bin got %0d exp 5", bus.bin_out); else pass_cnt++;
    chk_cnt++; if (bus.up !== 1'b0) $display("FAIL down_up got %b exp 0", bus.up); else pass_cnt++;
    settle(4'b0101);
  endtask

  task automatic test_clr_err();
    logic [7:0] exp_cnt;
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk_cnt++; if (bus.step_err !== 1'b0) $display("FAIL clr_alone got %b exp 0", bus.step_err); else pass_cnt++;
    chk_cnt++; if (bus.err_cnt !== 8'd0) $display("FAIL clr_alone_cnt got %0d exp 0", bus.err_cnt); else pass_cnt++;
    // 0101 -> 0000 is illegal (two bits).
    settle(4'b0000);
`ifdef GRAY_PTR_DECODER_ERR_CNT_EN
    exp_cnt = 8'd1;
`else
    exp_cnt = 8'd0;
`endif
    chk_cnt++; if (bus.step_err !== 1'b1) $display("FAIL reerr got %b exp 1", bus.step_err); else pass_cnt++;
    chk_cnt++; if (bus.err_cnt !== exp_cnt) $display("FAIL reerr_cnt got %0d exp %0d", bus.err_cnt, exp_cnt); else pass_cnt++;
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    // 0000 -> 0011 illegal, coinciding with clr_err at the compare edge.
    bus.gray_in = 4'b0011;
    tick(); tick();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk_cnt++; if (bus.step_err !== 1'b1) $display("FAIL clr_vs_set got %b exp 1", bus.step_err); else pass_cnt++;
    chk_cnt++; if (bus.bin_out !== 4'd2) $display("FAIL clr_vs_set_bin got %0d exp 2", bus.bin_out); else pass_cnt++;
    chk_cnt++; if (bus.up !== 1'b0) $display("FAIL clr_vs_set_up got %b exp 0", bus.up); else pass_cnt++;
    chk_cnt++; if (bus.err_cnt !== exp_cnt) $display("FAIL clr_vs_set_cnt got %0d exp %0d", bus.err_cnt, exp_cnt); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_bin [3] = '{4'd1, 4'd2, 4'd3};
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    settle(4'b0001);
    settle(4'b0000);
    chk_cnt++; if (bus.step_err !== 1'b0) $display("FAIL b2b_pre_err got %b exp 0", bus.step_err); else pass_cnt++;
    bus.gray_in = 4'b0001; tick();
    bus.gray_in = 4'b0011; tick();
    bus.gray_in = 4'b0010; tick();
    for (int k = 0; k < 3; k++) begin
      chk_cnt++; if (bus.bin_valid !== 1'b1) $display("FAIL b2b_valid k=%0d got %b exp 1", k, bus.bin_valid); else pass_cnt++;
      chk_cnt++; if (bus.bin_out !== exp_bin[k]) $display("FAIL b2b_bin k=%0d got %0d exp %0d", k, bus.bin_out, exp_bin[k]); else pass_cnt++;
      chk_cnt++; if (bus.up !== 1'b1) $display("FAIL b2b_up k=%0d got %b exp 1", k, bus.up); else pass_cnt++;
      tick();
    end
    chk_cnt++; if (bus.bin_valid !== 1'b0) $display("FAIL b2b_end got %b exp 0", bus.bin_valid); else pass_cnt++;
    chk_cnt++; if (bus.step_err !== 1'b0) $display("FAIL b2b_err got %b exp 0", bus.step_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int b = 4; b <= 9; b++) settle(gtab[b]);
    chk_cnt++; if (bus.bin_out !== 4'd9) $display("FAIL mid_pre_bin got %0d exp 9", bus.bin_out); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (bus.bin_out !== 4'd0) $display("FAIL mid_rst_bin got %0d exp 0", bus.bin_out); else pass_cnt++;
    chk_cnt++; if (bus.up !== 1'b0) $display("FAIL mid_rst_up got %b exp 0", bus.up); else pass_cnt++;
    chk_cnt++; if (bus.bin_valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", bus.bin_valid); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    // Held 1101 is compared against g_prev=0: three bits differ.
    repeat (3) tick();
    chk_cnt++; if (bus.bin_out !== 4'd9) $display("FAIL post_rst_bin got %0d exp 9", bus.bin_out); else pass_cnt++;
    chk_cnt++; if (bus.bin_valid !== 1'b1) $display("FAIL post_rst_valid got %b exp 1", bus.bin_valid); else pass_cnt++;
    chk_cnt++; if (bus.up !== 1'b0) $display("FAIL post_rst_up got %b exp 0", bus.up); else pass_cnt++;
    chk_cnt++; if (bus.step_err !== 1'b1) $display("FAIL post_rst_err got %b exp 1", bus.step_err); else pass_cnt++;
  endtask

  task automatic test_err_cnt();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    // Every change below flips two or more bits.
    for (int i = 0; i < 300; i++) begin
      bus.gray_in = (i % 2 == 0) ? 4'b0000 : 4'b0011;
      tick();
    end
    repeat (4) tick();
    chk_cnt++; if (bus.step_err !== 1'b1) $display("FAIL many_err got %b exp 1", bus.step_err); else pass_cnt++;
`ifdef GRAY_PTR_DECODER_ERR_CNT_EN
    chk_cnt++; if (bus.err_cnt !== 8'd255) $display("FAIL cnt_sat got %0d exp 255", bus.err_cnt); else pass_cnt++;
`else
    chk_cnt++; if (bus.err_cnt !== 8'd0) $display("FAIL cnt_tied got %0d exp 0", bus.err_cnt); else pass_cnt++;
`endif
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk_cnt++; if (bus.err_cnt !== 8'd0) $display("FAIL cnt_clr got %0d exp 0", bus.err_cnt); else pass_cnt++;
    chk_cnt++; if (bus.step_err !== 1'b0) $display("FAIL cnt_clr_err got %b exp 0", bus.step_err); else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_sequence();
    test_wrap();
    test_clr_err();
    test_back_to_back();
    test_reset_mid();
    test_err_cnt();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
